inst_uncached_fetch_ctrl: RTL and testbench
===========================================

// Module: inst_uncached_fetch_ctrl
//
// PURPOSE
//   Sequences uncached instruction fetches for the fetch (I) stage over an SRAM-like bus.
//   - Issues one read per fetch PC and holds the returned word until the I stage consumes it.
//   - Presents the word to the I stage as instSramValid/instSramData.
//   - Drops stale responses after a pipeline flush.
//   - Sits between the I stage and the uncached instruction bus port; the cached path is not its concern.
//
// PARAMETERS
//   ADDR_W  32  fetch/bus address width
//   DATA_W  32  instruction word width
//
// PORTS
//   clk            in   1       core clock, all state updates on posedge
//   reset          in   1       synchronous, active-high
//   fetchReq       in   1       I stage needs an uncached word at fetchPc (held until consumed)
//   fetchPc        in   ADDR_W  fetch address, stable while fetchReq=1 and not consumed
//   fetchAdvance   in   1       I stage consumes the presented word this cycle
//   flush          in   1       exception/redirect flush; kills current fetch
//   instSramValid  out  1       instSramData valid for the I stage
//   instSramData   out  DATA_W  fetched instruction word
//   busReq         out  1       bus read request
//   busAddr        out  ADDR_W  bus read address
//   busAddrOk      in   1       bus accepted request this cycle (busReq & busAddrOk)
//   busDataOk      in   1       read data returned this cycle
//   busRdata       in   DATA_W  read data
//   busy           out  1       state != IDLE
//
// BEHAVIOUR
//   - One clock domain (clk); reset synchronous active-high.
//   - Reset: state=IDLE; all outputs 0; instSramData=0; latched addr=0. Outstanding bus transaction is
//     abandoned; the bus port shares this reset.
//   - At most one transaction is outstanding; no back-to-back issue.
//   - States:
//     IDLE:    fetchReq & !flush -> latch fetchPc, go ADDR. Flush, or no fetchReq -> stay.
//     ADDR:    busReq=1, busAddr=latched.
//                busAddrOk & !flush -> DATA
//                busAddrOk & flush  -> DISCARD
//                !busAddrOk & flush -> IDLE (request withdrawn; legal only because not yet accepted)
//     DATA:    busReq=0. busDataOk arriving in the same cycle as busAddrOk is not supported
//              (bus guarantees >=1 cycle).
//                busDataOk & !flush -> latch busRdata into instSramData, go READY
//                busDataOk & flush  -> IDLE, data dropped
//                !busDataOk & flush -> DISCARD
//     READY:   instSramValid=1, instSramData held.
//                fetchAdvance | flush -> IDLE, valid drops next cycle
//                otherwise hold indefinitely (I stage stalled by dStall/dmStall)
//     DISCARD: wait for busDataOk -> IDLE. valid never asserted; new fetchReq ignored; flush has no
//              further effect.
//   - instSramValid is registered, high only in READY.
//   - busReq/busAddr are decoded from state only (no combinational path from fetchReq).
//   - Minimum latency, fetchReq to instSramValid, with busAddrOk on first ADDR cycle and busDataOk one
//     cycle later: 3 cycles.
//       cycle 0: IDLE sees req
//       cycle 1: ADDR, accepted
//       cycle 2: DATA, data
//       cycle 3: READY
//   - fetchReq dropping while in ADDR/DATA without flush is a protocol violation; the transaction
//     completes and the word is presented anyway.
//   - busDataOk in IDLE/ADDR/READY is ignored (assertion in the bench).
//   - Addresses pass through unmodified; no alignment check (handled upstream as instIllegal).
//
// TESTING
//   1. Basic: fetchReq=1, fetchPc=0xBFC00000; busAddrOk cycle 1, busDataOk cycle 2 with
//      busRdata=0x3C1DBFC0 -> busReq=1 only in cycle 1 with busAddr=0xBFC00000;
//      instSramValid=1, instSramData=0x3C1DBFC0 at cycle 3.
//   2. Stall hold: as in 1, but fetchAdvance=0 for 5 cycles after READY -> valid/data held constant,
//      no new busReq; fetchAdvance=1 -> IDLE next cycle.
//   3. Flush in DATA: accepted at 0xBFC00010; flush 1 cycle before busDataOk -> DISCARD; returned word
//      never presented; next fetch 0xBFC00380 returns its own data.
//   4. Flush in ADDR with busAddrOk=0 -> IDLE next cycle, busReq deasserts, no DISCARD.
//      Flush coincident with busAddrOk -> DISCARD.
//   5. Addr backpressure: busAddrOk held 0 for 4 cycles -> busReq and busAddr stable all 4 cycles;
//      accepted on 5th -> DATA.
//   6. Reset mid-operation: reset=1 while in DATA -> IDLE next cycle, all outputs 0; subsequent fetch
//      completes normally.

Source files
------------

// File: rtl/inst_uncached_fetch_ctrl.sv
// Uncached instruction fetch sequencer between the I stage and an SRAM-like bus port.
// Issues one read per fetch PC, holds the word until consumed, and drops stale responses after flush.
module inst_uncached_fetch_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchPc,
    input  logic              fetchAdvance,
    input  logic              flush,
    output logic              instSramValid,
    output logic [DATA_W-1:0] instSramData,
    output logic              busReq,
    output logic [ADDR_W-1:0] busAddr,
    input  logic              busAddrOk,
    input  logic              busDataOk,
    input  logic [DATA_W-1:0] busRdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        READY,
        DISCARD
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] dataQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addrQ <= '0;
            dataQ <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && fetchReq && !flush) begin
                addrQ <= fetchPc;
            end
            if (state == DATA && busDataOk && !flush) begin
                dataQ <= busRdata;
            end
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (fetchReq && !flush) stateNext = ADDR;
            end
            ADDR: begin
                // Withdrawing an unaccepted request is safe; once accepted the response must be drained.
                if (busAddrOk) stateNext = flush ? DISCARD : DATA;
                else if (flush) stateNext = IDLE;
            end
            DATA: begin
                if (busDataOk) stateNext = flush ? IDLE : READY;
                else if (flush) stateNext = DISCARD;
            end
            READY: begin
                if (fetchAdvance || flush) stateNext = IDLE;
            end
            DISCARD: begin
                if (busDataOk) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // All outputs decode from registered state so there is no path from fetchReq to the bus.
    assign busReq        = (state == ADDR);
    assign busAddr       = addrQ;
    assign instSramValid = (state == READY);
    assign instSramData  = dataQ;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_inst_uncached_fetch_ctrl.sv
// Directed self-checking bench for inst_uncached_fetch_ctrl.
module tb_inst_uncached_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetchReq;
    logic [31:0] fetchPc;
    logic        fetchAdvance;
    logic        flush;
    logic        instSramValid;
    logic [31:0] instSramData;
    logic        busReq;
    logic [31:0] busAddr;
    logic        busAddrOk;
    logic        busDataOk;
    logic [31:0] busRdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    inst_uncached_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .fetchReq(fetchReq), .fetchPc(fetchPc),
        .fetchAdvance(fetchAdvance), .flush(flush), .instSramValid(instSramValid),
        .instSramData(instSramData), .busReq(busReq), .busAddr(busAddr),
        .busAddrOk(busAddrOk), .busDataOk(busDataOk), .busRdata(busRdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bus must only return data while a read is outstanding (DATA or DISCARD).
    always @(posedge clk) begin
        if (!reset && busDataOk) begin
            assert (busy && !busReq && !instSramValid)
                else $error("busDataOk outside DATA/DISCARD");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        fetchReq = 1'b0; fetchPc = '0; fetchAdvance = 1'b0; flush = 1'b0;
        busAddrOk = 1'b0; busDataOk = 1'b0; busRdata = '0;
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({busReq, instSramValid, busy} !== 3'b000 || busAddr !== 32'h0 || instSramData !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req/valid/busy=%b%b%b addr=%h data=%h, required 000 0 0",
                     busReq, instSramValid, busy, busAddr, instSramData);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        fetchReq = 1'b1; fetchPc = 32'hBFC00000;
        checks++;
        if (busReq !== 1'b0) begin errors++; $display("FAIL basic_c0_req: got %b, required 0", busReq); end
        step();
        checks++;
        if (busReq !== 1'b1 || busAddr !== 32'hBFC00000) begin
            errors++; $display("FAIL basic_c1_bus: req=%b addr=%h, required 1 bfc00000", busReq, busAddr);
        end
        busAddrOk = 1'b1;
        step();
        busAddrOk = 1'b0;
        checks++;
        if (busReq !== 1'b0 || instSramValid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_c2_data: req=%b valid=%b busy=%b, required 0 0 1", busReq, instSramValid, busy);
        end
        busDataOk = 1'b1; busRdata = 32'h3C1DBFC0;
        step();
        busDataOk = 1'b0; busRdata = '0;
        checks++;
        if (instSramValid !== 1'b1 || instSramData !== 32'h3C1DBFC0 || busReq !== 1'b0) begin
            errors++; $display("FAIL basic_c3_ready: valid=%b data=%h req=%b, required 1 3c1dbfc0 0",
                               instSramValid, instSramData, busReq);
        end
        fetchAdvance = 1'b1; fetchReq = 1'b0;
        step();
        fetchAdvance = 1'b0;
        checks++;
        if (instSramValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_consume: valid=%b busy=%b, required 0 0", instSramValid, busy);
        end
    endtask

    task automatic test_stall_hold();
        fetchReq = 1'b1; fetchPc = 32'hBFC00004;
        step();
        busAddrOk = 1'b1;
        step();
        busAddrOk = 1'b0; busDataOk = 1'b1; busRdata = 32'h24080001;
        step();
        busDataOk = 1'b0; busRdata = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            checks++;
            if (instSramValid !== 1'b1 || instSramData !== 32'h24080001 || busReq !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: valid=%b data=%h req=%b, required 1 24080001 0",
                                   i, instSramValid, instSramData, busReq);
            end
        end
        fetchAdvance = 1'b1; fetchReq = 1'b0;
        step();
        fetchAdvance = 1'b0;
        checks++;
        if (instSramValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_release: valid=%b busy=%b, required 0 0", instSramValid, busy);
        end
    endtask

    task automatic test_flush_data();
        fetchReq = 1'b1; fetchPc = 32'hBFC00010;
        step();
        busAddrOk = 1'b1;
        step();
        busAddrOk = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || busReq !== 1'b0 || instSramValid !== 1'b0) begin
            errors++; $display("FAIL flushdata_discard: busy=%b req=%b valid=%b, required 1 0 0", busy, busReq, instSramValid);
        end
        // New request while discarding must be ignored until the stale word drains.
        fetchReq = 1'b1; fetchPc = 32'hBFC00380;
        step();
        checks++;
        if (busy !== 1'b1 || busReq !== 1'b0) begin
            errors++; $display("FAIL flushdata_wait: busy=%b req=%b, required 1 0", busy, busReq);
        end
        busDataOk = 1'b1; busRdata = 32'hDEADBEEF;
        step();
        busDataOk = 1'b0; busRdata = '0;
        checks++;
        if (instSramValid !== 1'b0 || busReq !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flushdata_drop: valid=%b req=%b busy=%b, required 0 0 0", instSramValid, busReq, busy);
        end
        step();
        checks++;
        if (busReq !== 1'b1 || busAddr !== 32'hBFC00380) begin
            errors++; $display("FAIL flushdata_next_addr: req=%b addr=%h, required 1 bfc00380", busReq, busAddr);
        end
        busAddrOk = 1'b1;
        step();
        busAddrOk = 1'b0; busDataOk = 1'b1; busRdata = 32'h401A6800;
        step();
        busDataOk = 1'b0; busRdata = '0;
        checks++;
        if (instSramValid !== 1'b1 || instSramData !== 32'h401A6800) begin
            errors++; $display("FAIL flushdata_next_data: valid=%b data=%h, required 1 401a6800", instSramValid, instSramData);
        end
        fetchAdvance = 1'b1; fetchReq = 1'b0;
        step();
        fetchAdvance = 1'b0;
    endtask

    task automatic test_flush_addr();
        fetchReq = 1'b1; fetchPc = 32'hBFC00020;
        step();
        flush = 1'b1; fetchReq = 1'b0;
        step();
        flush = 1'b0;
        checks++;
        if (busReq !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flushaddr_withdraw: req=%b busy=%b, required 0 0", busReq, busy);
        end
        fetchReq = 1'b1; fetchPc = 32'hBFC00024;
        step();
        flush = 1'b1; busAddrOk = 1'b1; fetchReq = 1'b0;
        step();
        flush = 1'b0; busAddrOk = 1'b0;
        checks++;
        if (busy !== 1'b1 || busReq !== 1'b0) begin
            errors++; $display("FAIL flushaddr_discard: busy=%b req=%b, required 1 0", busy, busReq);
        end
        busDataOk = 1'b1; busRdata = 32'h11111111;
        step();
        busDataOk = 1'b0; busRdata = '0;
        checks++;
        if (instSramValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flushaddr_drop: valid=%b busy=%b, required 0 0", instSramValid, busy);
        end
    endtask

    task automatic test_addr_backpressure();
        fetchReq = 1'b1; fetchPc = 32'hBFC00040;
        step();
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if (busReq !== 1'b1 || busAddr !== 32'hBFC00040) begin
                errors++; $display("FAIL backpressure[%0d]: req=%b addr=%h, required 1 bfc00040", i, busReq, busAddr);
            end
            step();
        end
        busAddrOk = 1'b1;
        checks++;
        if (busReq !== 1'b1) begin errors++; $display("FAIL backpressure_5th: req=%b, required 1", busReq); end
        step();
        busAddrOk = 1'b0;
        checks++;
        if (busReq !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL backpressure_data: req=%b busy=%b, required 0 1", busReq, busy);
        end
        busDataOk = 1'b1; busRdata = 32'h8C020000;
        step();
        busDataOk = 1'b0; busRdata = '0;
        checks++;
        if (instSramValid !== 1'b1 || instSramData !== 32'h8C020000) begin
            errors++; $display("FAIL backpressure_ready: valid=%b data=%h, required 1 8c020000", instSramValid, instSramData);
        end
        fetchAdvance = 1'b1; fetchReq = 1'b0;
        step();
        fetchAdvance = 1'b0;
    endtask

    task automatic test_reset_mid();
        fetchReq = 1'b1; fetchPc = 32'hBFC00100;
        step();
        busAddrOk = 1'b1;
        step();
        busAddrOk = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; fetchReq = 1'b0;
        checks++;
        if ({busReq, instSramValid, busy} !== 3'b000 || busAddr !== 32'h0 || instSramData !== 32'h0) begin
            errors++; $display("FAIL resetmid_outputs: req/valid/busy=%b%b%b addr=%h data=%h, required 000 0 0",
                               busReq, instSramValid, busy, busAddr, instSramData);
        end
        fetchReq = 1'b1; fetchPc = 32'hBFC00200;
        step();
        checks++;
        if (busReq !== 1'b1 || busAddr !== 32'hBFC00200) begin
            errors++; $display("FAIL resetmid_addr: req=%b addr=%h, required 1 bfc00200", busReq, busAddr);
        end
        busAddrOk = 1'b1;
        step();
        busAddrOk = 1'b0; busDataOk = 1'b1; busRdata = 32'hAFBF0018;
        step();
        busDataOk = 1'b0; busRdata = '0;
        checks++;
        if (instSramValid !== 1'b1 || instSramData !== 32'hAFBF0018) begin
            errors++; $display("FAIL resetmid_data: valid=%b data=%h, required 1 afbf0018", instSramValid, instSramData);
        end
        fetchAdvance = 1'b1; fetchReq = 1'b0;
        step();
        fetchAdvance = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_hold();
        test_flush_data();
        test_flush_addr();
        test_addr_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
